// File: rtl/hk_pkg.sv
// Shared parameters, FSM state type and ROM image for the SHA-2 constant store.
package hk_pkg;

  localparam int unsigned DEF_WORD_W  = 32;
  localparam int unsigned DEF_H_WORDS = 8;
  localparam int unsigned DEF_K_WORDS = 64;
  localparam int unsigned DEF_N_SETS  = 2;
  localparam int unsigned ROM_AW      = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } hk_state_e;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned rom_h_base(input int unsigned set, input int unsigned h_words);
    return set * h_words;
  endfunction

  function automatic int unsigned rom_k_base(input int unsigned n_sets, input int unsigned h_words);
    return n_sets * h_words;
  endfunction

  function automatic int unsigned ram_depth(input int unsigned h_words, input int unsigned k_words);
    return h_words + k_words;
  endfunction

  localparam logic [31:0] SHA2_IV [2][8] = '{
    '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19},
    '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4}
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Image word: low 32 bits are the SHA-256 table value, upper 32 bits its
  // complement (wide builds). K entries past 63 fold back with the index folded in.
  function automatic logic [63:0] rom_image(input int unsigned addr, input int unsigned n_sets,
                                            input int unsigned h_words, input int unsigned k_words);
    int unsigned kb;
    int unsigned s;
    int unsigned j;
    logic [31:0] lo;
    logic [63:0] w;
    kb = rom_k_base(n_sets, h_words);
    s  = 0;
    j  = 0;
    lo = '0;
    w  = '0;
    if (addr < kb) begin
      s = addr / h_words;
      j = addr % h_words;
      if (s < 2 && j < 8) begin
        lo = SHA2_IV[s[0]][j[2:0]];
        w  = {~lo, lo};
      end
    end else if (addr - kb < k_words) begin
      j  = addr - kb;
      lo = SHA256_K[j[5:0]] ^ {j[31:6], 6'b0};
      w  = {~lo, lo};
    end
    return w;
  endfunction

endpackage

// File: rtl/hk_copy_seq.sv
// Copy sequencer: walks the ROM image for the selected H set plus the K table
// and produces a one-cycle-delayed RAM write strobe aligned with ROM data.
module hk_copy_seq
  import hk_pkg::*;
#(
  parameter int unsigned H_WORDS = DEF_H_WORDS,
  parameter int unsigned K_WORDS = DEF_K_WORDS,
  parameter int unsigned N_SETS  = DEF_N_SETS
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          copy_req,
  input  logic [sel_w(N_SETS)-1:0]                      mode,
  output logic                                          copy_err,
  output logic                                          rdy,
  output logic [sel_w(N_SETS)-1:0]                      active_set,
  output logic [ROM_AW-1:0]                             rom_addr,
  output logic                                          wr_en,
  output logic [idx_w(ram_depth(H_WORDS, K_WORDS))-1:0] wr_addr
);

  localparam int unsigned DEPTH  = ram_depth(H_WORDS, K_WORDS);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 2);
  localparam int unsigned MODE_W = sel_w(N_SETS);
  localparam int unsigned RAM_AW = idx_w(DEPTH);

  hk_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MODE_W-1:0]   set_q, set_d;
  logic                copy_err_q, copy_err_d;
  logic                wr_en_q, wr_en_d;
  logic [RAM_AW-1:0]   wr_addr_q, wr_addr_d;
  int unsigned         rom_idx;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    set_d      = set_q;
    copy_err_d = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (copy_req) begin
          if (32'(mode) < N_SETS) begin
            state_d = ST_COPY;
            cnt_d   = '0;
            set_d   = mode;
          end else begin
            copy_err_d = 1'b1;
          end
        end
      end
      ST_COPY: begin
        if (cnt_q < CNT_W'(DEPTH)) begin
          wr_en_d   = 1'b1;
          wr_addr_d = RAM_AW'(cnt_q);
        end
        // Two extra counts cover ROM latency and the final RAM write.
        if (cnt_q == CNT_W'(DEPTH + 1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_idx = 32'(cnt_q);
    if (rom_idx < H_WORDS) begin
      rom_addr = ROM_AW'(rom_h_base(32'(set_q), H_WORDS) + rom_idx);
    end else begin
      rom_addr = ROM_AW'(rom_k_base(N_SETS, H_WORDS) + rom_idx - H_WORDS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      set_q      <= '0;
      copy_err_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      set_q      <= set_d;
      copy_err_q <= copy_err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign rdy        = (state_q == ST_DONE);
  assign active_set = set_q;
  assign copy_err   = copy_err_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;

endmodule

// File: rtl/hk_const_store.sv
// SHA-2 H/K constant store: ROM image bootstrapped into RAM on COPY, then
// single-word registered reads with valid/error pulses.
module hk_const_store
  import hk_pkg::*;
#(
  parameter int unsigned WORD_W  = DEF_WORD_W,
  parameter int unsigned H_WORDS = DEF_H_WORDS,
  parameter int unsigned K_WORDS = DEF_K_WORDS,
  parameter int unsigned N_SETS  = DEF_N_SETS
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     COPY,
  input  logic [sel_w(N_SETS)-1:0] MODE,
  input  logic                     RD_EN,
  input  logic                     HK_SEL,
  input  logic [idx_w(K_WORDS)-1:0] ADDR,
  output logic [WORD_W-1:0]        RD_DATA,
  output logic                     RD_VALID,
  output logic                     RD_ERR,
  output logic                     COPY_ERR,
  output logic                     RDY,
  output logic [sel_w(N_SETS)-1:0] ACTIVE_SET
);

  localparam int unsigned DEPTH  = ram_depth(H_WORDS, K_WORDS);
  localparam int unsigned RAM_AW = idx_w(DEPTH);

  logic [ROM_AW-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data_q, rom_data_d;
  logic              wr_en;
  logic [RAM_AW-1:0] wr_addr;
  logic              rdy;
  logic [WORD_W-1:0] mem [DEPTH];

  logic [RAM_AW-1:0] phys;
  logic              oob;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;

  hk_copy_seq #(
    .H_WORDS (H_WORDS),
    .K_WORDS (K_WORDS),
    .N_SETS  (N_SETS)
  ) u_seq (
    .clk        (CLK),
    .rst_n      (RST_N),
    .copy_req   (COPY),
    .mode       (MODE),
    .copy_err   (COPY_ERR),
    .rdy        (rdy),
    .active_set (ACTIVE_SET),
    .rom_addr   (rom_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr)
  );

  // Synchronous-read ROM image, one cycle latency.
  always_comb rom_data_d = WORD_W'(rom_image(32'(rom_addr), N_SETS, H_WORDS, K_WORDS));

  always_ff @(posedge CLK) rom_data_q <= rom_data_d;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= rom_data_q;
  end

  always_comb begin
    phys       = HK_SEL ? (RAM_AW'(H_WORDS) + RAM_AW'(ADDR)) : RAM_AW'(ADDR);
    oob        = HK_SEL ? (32'(ADDR) >= K_WORDS) : (32'(ADDR) >= H_WORDS);
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_err_d   = 1'b0;
    if (RD_EN && rdy) begin
      rd_valid_d = 1'b1;
      if (oob) begin
        rd_err_d  = 1'b1;
        rd_data_d = '0;
      end else begin
        rd_data_d = mem[phys];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign RD_ERR   = rd_err_q;
  assign RDY      = rdy;

endmodule

// File: tb/tb_hk_const_store.sv
// Directed bench for hk_const_store: default SHA-256/224 build plus a
// 64-bit, single-set, 80-entry K build.
module tb_hk_const_store;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_copy, a_mode, a_rd_en, a_hk_sel;
  logic [5:0]  a_addr;
  logic [31:0] a_rd_data;
  logic        a_rd_valid, a_rd_err, a_copy_err, a_rdy, a_active_set;

  logic        b_copy, b_mode, b_rd_en, b_hk_sel;
  logic [6:0]  b_addr;
  logic [63:0] b_rd_data;
  logic        b_rd_valid, b_rd_err, b_copy_err, b_rdy, b_active_set;

  int checks   = 0;
  int failures = 0;
  int k;

  always #5 clk = ~clk;

  hk_const_store dut_a (
    .CLK(clk), .RST_N(rst_n), .COPY(a_copy), .MODE(a_mode), .RD_EN(a_rd_en),
    .HK_SEL(a_hk_sel), .ADDR(a_addr), .RD_DATA(a_rd_data), .RD_VALID(a_rd_valid),
    .RD_ERR(a_rd_err), .COPY_ERR(a_copy_err), .RDY(a_rdy), .ACTIVE_SET(a_active_set)
  );

  hk_const_store #(.WORD_W(64), .H_WORDS(8), .K_WORDS(80), .N_SETS(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .COPY(b_copy), .MODE(b_mode), .RD_EN(b_rd_en),
    .HK_SEL(b_hk_sel), .ADDR(b_addr), .RD_DATA(b_rd_data), .RD_VALID(b_rd_valid),
    .RD_ERR(b_rd_err), .COPY_ERR(b_copy_err), .RDY(b_rdy), .ACTIVE_SET(b_active_set)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy_a(input int start, output int n);
    n = start;
    while (!a_rdy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rdy_b(input int start, output int n);
    n = start;
    while (!b_rdy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic rd_a(input logic sel, input logic [5:0] addr);
    a_rd_en = 1'b1; a_hk_sel = sel; a_addr = addr;
    tick();
  endtask

  task automatic rd_b(input logic sel, input logic [6:0] addr);
    b_rd_en = 1'b1; b_hk_sel = sel; b_addr = addr;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    a_copy = 1'b0; a_mode = 1'b0; a_rd_en = 1'b0; a_hk_sel = 1'b0; a_addr = '0;
    b_copy = 1'b0; b_mode = 1'b0; b_rd_en = 1'b0; b_hk_sel = 1'b0; b_addr = '0;
    tick(); tick();
    chk("rst_rdy", 64'(a_rdy), 64'd0);
    chk("rst_rd_data", 64'(a_rd_data), 64'd0);
    chk("rst_rd_valid", 64'(a_rd_valid), 64'd0);
    chk("rst_rd_err", 64'(a_rd_err), 64'd0);
    chk("rst_copy_err", 64'(a_copy_err), 64'd0);
    chk("rst_active_set", 64'(a_active_set), 64'd0);
    chk("rst_b_rd_data", b_rd_data, 64'd0);
    rst_n = 1'b1;

    rd_a(1'b0, 6'd0);
    a_rd_en = 1'b0;
    chk("idle_rd_valid", 64'(a_rd_valid), 64'd0);

    // Load SHA-256 IV; RD_EN during copy must be dropped.
    a_copy = 1'b1; a_mode = 1'b0;
    tick();
    a_copy = 1'b0;
    chk("copy_rdy_low", 64'(a_rdy), 64'd0);
    rd_a(1'b1, 6'd0);
    a_rd_en = 1'b0;
    chk("copy_rd_valid", 64'(a_rd_valid), 64'd0);
    wait_rdy_a(1, k);
    chk("rdy_latency_m0", 64'(k), 64'd74);

    rd_a(1'b0, 6'd0);
    chk("h0_m0", 64'(a_rd_data), 64'h6a09e667);
    chk("h0_valid", 64'(a_rd_valid), 64'd1);
    rd_a(1'b0, 6'd7);
    chk("h7_m0", 64'(a_rd_data), 64'h5be0cd19);
    chk("b2b_valid1", 64'(a_rd_valid), 64'd1);
    rd_a(1'b1, 6'd0);
    chk("k0", 64'(a_rd_data), 64'h428a2f98);
    chk("b2b_valid2", 64'(a_rd_valid), 64'd1);
    rd_a(1'b1, 6'd63);
    chk("k63", 64'(a_rd_data), 64'hc67178f2);
    chk("k63_err", 64'(a_rd_err), 64'd0);
    a_rd_en = 1'b0;
    tick();
    chk("idle_valid_low", 64'(a_rd_valid), 64'd0);
    chk("rd_data_hold", 64'(a_rd_data), 64'hc67178f2);
    rd_a(1'b0, 6'd8);
    chk("oob_h_data", 64'(a_rd_data), 64'd0);
    chk("oob_h_valid", 64'(a_rd_valid), 64'd1);
    chk("oob_h_err", 64'(a_rd_err), 64'd1);
    a_rd_en = 1'b0;
    tick();
    chk("oob_err_pulse", 64'(a_rd_err), 64'd0);

    // Reload SHA-224 IV with a simultaneous read of the old contents.
    a_copy = 1'b1; a_mode = 1'b1;
    rd_a(1'b0, 6'd0);
    a_copy = 1'b0; a_rd_en = 1'b0;
    chk("reload_rdy_low", 64'(a_rdy), 64'd0);
    chk("reload_old_read", 64'(a_rd_data), 64'h6a09e667);
    chk("reload_active_set", 64'(a_active_set), 64'd1);
    a_copy = 1'b1; a_mode = 1'b0;
    tick();
    a_copy = 1'b0;
    chk("copy_in_copy_err", 64'(a_copy_err), 64'd0);
    chk("copy_in_copy_set", 64'(a_active_set), 64'd1);
    wait_rdy_a(1, k);
    chk("rdy_latency_m1", 64'(k), 64'd74);
    rd_a(1'b0, 6'd0);
    chk("h0_m1", 64'(a_rd_data), 64'hc1059ed8);
    rd_a(1'b0, 6'd7);
    chk("h7_m1", 64'(a_rd_data), 64'hbefa4fa4);
    rd_a(1'b1, 6'd0);
    chk("k0_after_reload", 64'(a_rd_data), 64'h428a2f98);
    rd_a(1'b1, 6'd63);
    chk("k63_after_reload", 64'(a_rd_data), 64'hc67178f2);
    a_rd_en = 1'b0;

    // Reset in the middle of a copy (counter = 30).
    a_copy = 1'b1; a_mode = 1'b1;
    tick();
    a_copy = 1'b0;
    repeat (30) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rdy", 64'(a_rdy), 64'd0);
    chk("midrst_active_set", 64'(a_active_set), 64'd0);
    chk("midrst_rd_data", 64'(a_rd_data), 64'd0);
    chk("midrst_rd_valid", 64'(a_rd_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("postrst_rdy", 64'(a_rdy), 64'd0);
    a_copy = 1'b1; a_mode = 1'b0;
    tick();
    a_copy = 1'b0;
    wait_rdy_a(0, k);
    chk("rdy_latency_fresh", 64'(k), 64'd74);
    rd_a(1'b0, 6'd0);
    chk("h0_fresh", 64'(a_rd_data), 64'h6a09e667);
    rd_a(1'b1, 6'd5);
    chk("k5_fresh", 64'(a_rd_data), 64'h59f111f1);
    a_rd_en = 1'b0;

    // Wide build: MODE=1 is out of range with a single set.
    b_copy = 1'b1; b_mode = 1'b1;
    tick();
    b_copy = 1'b0;
    chk("b_copy_err", 64'(b_copy_err), 64'd1);
    chk("b_copy_err_rdy", 64'(b_rdy), 64'd0);
    tick();
    chk("b_copy_err_pulse", 64'(b_copy_err), 64'd0);
    chk("b_idle_kept", 64'(b_rdy), 64'd0);
    b_copy = 1'b1; b_mode = 1'b0;
    tick();
    b_copy = 1'b0;
    wait_rdy_b(0, k);
    chk("b_rdy_latency", 64'(k), 64'd90);
    rd_b(1'b0, 7'd7);
    chk("b_h7", b_rd_data, 64'ha41f32e6_5be0cd19);
    rd_b(1'b1, 7'd79);
    chk("b_k79", b_rd_data, 64'h3e640ecb_c19bf134);
    chk("b_k79_err", 64'(b_rd_err), 64'd0);
    rd_b(1'b1, 7'd0);
    chk("b_k0", b_rd_data, 64'hbd75d067_428a2f98);
    rd_b(1'b1, 7'd80);
    chk("b_oob_k_data", b_rd_data, 64'd0);
    chk("b_oob_k_err", 64'(b_rd_err), 64'd1);
    b_rd_en = 1'b0;
    b_copy = 1'b1; b_mode = 1'b1;
    tick();
    b_copy = 1'b0;
    chk("b_done_copy_err", 64'(b_copy_err), 64'd1);
    chk("b_done_kept", 64'(b_rdy), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
